// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, default halt
// opcode and the field layout of an instruction word.
package instr_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [3:0] HALT_FUNC_DEFAULT = 4'hF;

   localparam int FUNC_MSB    = 7;
   localparam int FUNC_LSB    = 4;
   localparam int OPERAND_MSB = 3;
   localparam int OPERAND_LSB = 0;

endpackage

// File: rtl/pc_counter.sv
// Program counter: wraps modulo 2^PC_W; a synchronous clear takes priority
// over the increment enable.
module pc_counter #(
   parameter int PC_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            clr,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (clr) begin
         pc <= '0;
      end else if (en) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: fetches instruction words from address PC, presents
// func/operand to the decoder and pulses exec_valid once per executed instruction.
module instr_sequencer
   import instr_seq_pkg::*;
#(
   parameter int         PC_W      = 4,
   parameter logic [3:0] HALT_FUNC = HALT_FUNC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [PC_W-1:0] instr_addr,
   output logic            instr_req,
   input  logic            instr_ack,
   input  logic [7:0]      instr_data,
   input  logic            stall,
   output logic [3:0]      func,
   output logic [3:0]      operand,
   output logic            exec_valid,
   output logic            busy,
   output logic            halted,
   output logic [7:0]      exec_count
);

   state_t state;
   logic   pc_en;
   logic   pc_clr;

   // The PC moves only on the EXEC exit edge and is zeroed whenever a run begins.
   assign pc_en  = (state == EXEC) && !stall;
   assign pc_clr = start && ((state == IDLE) || (state == HALT));

   pc_counter #(.PC_W(PC_W)) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pc_en),
      .clr   (pc_clr),
      .pc    (instr_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         func       <= '0;
         operand    <= '0;
         exec_count <= '0;
         instr_req  <= 1'b0;
         exec_valid <= 1'b0;
         busy       <= 1'b0;
         halted     <= 1'b0;
      end else begin
         exec_valid <= 1'b0;
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  state      <= FETCH;
                  instr_req  <= 1'b1;
                  busy       <= 1'b1;
                  halted     <= 1'b0;
                  exec_count <= '0;
               end
            end
            FETCH: begin
               if (instr_ack) begin
                  func      <= instr_data[FUNC_MSB:FUNC_LSB];
                  operand   <= instr_data[OPERAND_MSB:OPERAND_LSB];
                  instr_req <= 1'b0;
                  if (instr_data[FUNC_MSB:FUNC_LSB] == HALT_FUNC) begin
                     state  <= HALT;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end else begin
                     state  <= EXEC;
                  end
               end
            end
            EXEC: begin
               // Pulse lands the cycle after the exit edge, while func/operand
               // still hold the value latched on the previous acknowledge.
               if (!stall) begin
                  exec_valid <= 1'b1;
                  state      <= FETCH;
                  instr_req  <= 1'b1;
                  if (exec_count != 8'hFF) begin
                     exec_count <= exec_count + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
